// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-2 FFT stage sequencer:
//   - seq_state_e   : sequencer FSM states
//   - *_DEFAULT     : default transform size / pipeline latency
//   - layer_width() : width of the layer index port (never below 1 bit)
//   - bfly_*()      : butterfly A/B read address and twiddle address for
//                     butterfly k of layer L
// The helpers work in 32-bit unsigned arithmetic; callers truncate to the
// address widths, which is lossless because A, B < N and tw < N/2.
// -----------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned FFT_SIZE_DEFAULT = 8;
  localparam int unsigned PIPE_LAT_DEFAULT = 2;

  // Width needed to hold layer indices 0..log2(N)-1.
  function automatic int unsigned layer_width(input int unsigned fft_size);
    int unsigned w;
    w = $clog2($clog2(fft_size));
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

  // Position of butterfly k inside its group of 2^L butterflies.
  function automatic int unsigned bfly_pos(input int unsigned k, input int unsigned layer);
    return k & ((32'd1 << layer) - 32'd1);
  endfunction

  // Upper-leg address: group index moved up one bit, position kept in the low bits.
  function automatic int unsigned bfly_addr_a(input int unsigned k, input int unsigned layer);
    return ((k >> layer) << (layer + 32'd1)) | bfly_pos(k, layer);
  endfunction

  // Lower leg sits exactly one butterfly span (2^L) above the upper leg.
  function automatic int unsigned bfly_addr_b(input int unsigned k, input int unsigned layer);
    return bfly_addr_a(k, layer) + (32'd1 << layer);
  endfunction

  // Twiddle index scales the in-group position up to the N/2-entry ROM.
  function automatic int unsigned bfly_twiddle(input int unsigned k, input int unsigned layer,
                                               input int unsigned log2n);
    return bfly_pos(k, layer) << (log2n - 32'd1 - layer);
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// -----------------------------------------------------------------------------
// fft_delay_line
// Fixed-depth shift register; every stage moves one place per clock.
// Ports:
//   clk   in            clock
//   clr_n in            synchronous active-low clear of every stage
//   d     in  [WIDTH]   data entering stage 0
//   q     out [WIDTH]   data leaving the last stage (d delayed DEPTH cycles)
// -----------------------------------------------------------------------------
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: every stage is cleared, not just the strobe bit -- a stale write
  // strobe or address surviving a clear would corrupt RAM after a restart.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
// Address/control sequencer for an in-place radix-2 FFT. One start pulse walks
// all log2(N) layers: N/2 read cycles per layer, then PIPE_LAT drain cycles so
// the last write of a layer lands before the next layer's first read.
// Write strobe/addresses are the read strobe/addresses delayed PIPE_LAT cycles.
//
// Ports:
//   i_CLK, i_RST_N       clock, synchronous active-low reset
//   i_start              start pulse, honoured only in IDLE
//   i_stall              (FFT_SEQ_STALL_EN only) pause issue during READ
//   o_busy               high in READ and DRAIN
//   o_done               one-cycle completion pulse
//   o_layer              current layer
//   o_rden               read strobe
//   o_rdaddr_A/_B        butterfly read addresses
//   o_rdaddr_tw          twiddle ROM address
//   o_wren               write strobe
//   o_wraddr_A/_B        butterfly write addresses
//
// Build option: define FFT_SEQ_STALL_EN to add the i_stall input.
// -----------------------------------------------------------------------------
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_SIZE       = FFT_SIZE_DEFAULT,
  parameter int ADDR_SIZE      = $clog2(FFT_SIZE),
  parameter int TWID_ADDR_SIZE = $clog2(FFT_SIZE / 2),
  parameter int PIPE_LAT       = PIPE_LAT_DEFAULT
) (
  input  logic                                i_CLK,
  input  logic                                i_RST_N,
  input  logic                                i_start,
`ifdef FFT_SEQ_STALL_EN
  input  logic                                i_stall,
`endif
  output logic                                o_busy,
  output logic                                o_done,
  output logic [layer_width(FFT_SIZE)-1:0]    o_layer,
  output logic                                o_rden,
  output logic [ADDR_SIZE-1:0]                o_rdaddr_A,
  output logic [ADDR_SIZE-1:0]                o_rdaddr_B,
  output logic [TWID_ADDR_SIZE-1:0]           o_rdaddr_tw,
  output logic                                o_wren,
  output logic [ADDR_SIZE-1:0]                o_wraddr_A,
  output logic [ADDR_SIZE-1:0]                o_wraddr_B
);

  localparam int LOG2N   = $clog2(FFT_SIZE);
  localparam int LAYER_W = layer_width(FFT_SIZE);
  localparam int K_W     = ADDR_SIZE - 1;
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DL_W    = 1 + 2 * ADDR_SIZE;

  localparam logic [K_W-1:0]     K_LAST     = K_W'(FFT_SIZE / 2 - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LOG2N - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  seq_state_e                state_q, state_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [LAYER_W-1:0]        layer_q, layer_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      rden_q, rden_d;
  logic [ADDR_SIZE-1:0]      rdaddr_a_q, rdaddr_a_d;
  logic [ADDR_SIZE-1:0]      rdaddr_b_q, rdaddr_b_d;
  logic [TWID_ADDR_SIZE-1:0] rdaddr_tw_q, rdaddr_tw_d;
  logic                      stall_req;
  logic [DL_W-1:0]           dl_out;

`ifdef FFT_SEQ_STALL_EN
  assign stall_req = i_stall;
`else
  assign stall_req = 1'b0;
`endif

  // State and counters describe the cycle the outputs are showing; every
  // butterfly shown in READ has already been issued, so a stall just repeats
  // the current addresses with the strobe low and resumes at k+1.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    layer_d     = layer_q;
    drain_d     = drain_q;
    rden_d      = 1'b0;
    rdaddr_a_d  = '0;
    rdaddr_b_d  = '0;
    rdaddr_tw_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_READ;
          k_d     = '0;
          layer_d = '0;
          rden_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else if (stall_req) begin
          rden_d = 1'b0;
        end else begin
          k_d    = k_q + K_W'(1);
          rden_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (layer_q == LAYER_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            layer_d = layer_q + LAYER_W'(1);
            k_d     = '0;
            rden_d  = 1'b1;
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        k_d     = '0;
        layer_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_READ) begin
      rdaddr_a_d  = ADDR_SIZE'(bfly_addr_a(32'(k_d), 32'(layer_d)));
      rdaddr_b_d  = ADDR_SIZE'(bfly_addr_b(32'(k_d), 32'(layer_d)));
      rdaddr_tw_d = TWID_ADDR_SIZE'(bfly_twiddle(32'(k_d), 32'(layer_d), LOG2N));
    end

    busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      layer_q     <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rden_q      <= 1'b0;
      rdaddr_a_q  <= '0;
      rdaddr_b_q  <= '0;
      rdaddr_tw_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      layer_q     <= layer_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rden_q      <= rden_d;
      rdaddr_a_q  <= rdaddr_a_d;
      rdaddr_b_q  <= rdaddr_b_d;
      rdaddr_tw_q <= rdaddr_tw_d;
    end
  end

  // Write side mirrors the registered read side PIPE_LAT cycles later.
  fft_delay_line #(
    .WIDTH(DL_W),
    .DEPTH(PIPE_LAT)
  ) u_wr_delay (
    .clk   (i_CLK),
    .clr_n (i_RST_N),
    .d     ({rden_q, rdaddr_a_q, rdaddr_b_q}),
    .q     (dl_out)
  );

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_layer     = layer_q;
  assign o_rden      = rden_q;
  assign o_rdaddr_A  = rdaddr_a_q;
  assign o_rdaddr_B  = rdaddr_b_q;
  assign o_rdaddr_tw = rdaddr_tw_q;
  assign o_wren      = dl_out[DL_W-1];
  assign o_wraddr_A  = dl_out[2*ADDR_SIZE-1:ADDR_SIZE];
  assign o_wraddr_B  = dl_out[ADDR_SIZE-1:0];

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Parametrised address and control sequencer for a complete in-place radix-2 FFT. One `i_start` pulse walks every butterfly layer in turn, and the sequencer produces, per butterfly:

- both read addresses,
- the twiddle-ROM address,
- the delayed write addresses and write enable.

Between layers it drains the butterfly pipeline so a layer never reads data the previous layer has not yet written. It sits between the shared sample RAM / twiddle ROM and the butterfly datapath, and replaces per-layer controllers.

## Interface
Parameters:
- `FFT_SIZE`, 8 — points; power of two, ≥4.
- `ADDR_SIZE`, `$clog2(FFT_SIZE)` — sample RAM address width.
- `TWID_ADDR_SIZE`, `$clog2(FFT_SIZE/2)` — twiddle ROM address width (ROM holds W_N^j, j = 0..N/2-1).
- `PIPE_LAT`, 2 — cycles from read address to butterfly result at the write port; ≥1.

Ports:
- `i_CLK`  in  1  — the single clock.
- `i_RST_N`  in  1  — reset, synchronous, active-low.
- `i_start`  in  1  — start pulse; sampled only in IDLE.
- `o_busy`  out  1  — high in READ and DRAIN.
- `o_done`  out  1  — one-cycle pulse when the transform is complete.
- `o_layer`  out  `$clog2($clog2(FFT_SIZE))`, min 1  — current layer L.
- `o_rden`  out  1  — read strobe.
- `o_rdaddr_A`, `o_rdaddr_B`  out  `ADDR_SIZE`  — butterfly read addresses.
- `o_rdaddr_tw`  out  `TWID_ADDR_SIZE`  — twiddle address.
- `o_wren`  out  1  — write strobe.
- `o_wraddr_A`, `o_wraddr_B`  out  `ADDR_SIZE`  — butterfly write addresses.

## Operation
- Let LOG2N = `$clog2(FFT_SIZE)`. Layers run L = 0..LOG2N-1.
- In layer L the butterfly counter k runs 0..N/2-1.
- Per-butterfly arithmetic, all in `ADDR_SIZE` bits with no overflow possible:
  - pos = k & (2^L - 1)
  - A = ((k >> L) << (L+1)) | pos
  - B = A + 2^L
  - tw = pos << (LOG2N-1-L)
- FSM states and transitions:
  - IDLE: outputs quiet. `i_start` = 1 → READ with L = 0, k = 0.
  - READ: `o_rden` = 1 with A/B/tw for the current k; k increments each cycle. At k = N/2-1 → DRAIN, drain count = 0.
  - DRAIN: `o_rden` = 0; counts PIPE_LAT cycles. On the last drain cycle:
    - if L = LOG2N-1 → DONE;
    - otherwise L+1, k = 0 → READ.
  - DONE: `o_done` = 1 for one cycle → IDLE.
- Write side: {`o_rden`, A, B} passes through a PIPE_LAT-stage delay line to {`o_wren`, `o_wraddr_A`, `o_wraddr_B`}. The delay line shifts every cycle, independent of state.
- `i_start` in any state other than IDLE is ignored.
- `i_start` in the same cycle as DONE is ignored. It must be re-asserted in IDLE.
- Reset mid-operation:
  - FSM returns to IDLE;
  - all counters clear;
  - the delay line flushes, so no stale write issues after reset.

## Timing
- Every output is registered.
- Reset values: `o_busy`, `o_done`, `o_rden`, `o_wren` = 0; all addresses = 0; `o_layer` = 0.
- `i_start` high in cycle c → `o_rden` high from cycle c+1.
- Each layer occupies N/2 + PIPE_LAT cycles.
- `o_done` is high in cycle c+1+LOG2N·(N/2+PIPE_LAT). For N=8, PIPE_LAT=2 this is c+19.
- Hazard guarantee: the last write of layer L (`o_wren` high in the final DRAIN cycle) precedes the first read of layer L+1 by one cycle.
- `o_wren` is always `o_rden` delayed by exactly PIPE_LAT cycles.

## Configuration
- `FFT_SEQ_STALL_EN` defined:
  - adds input `i_stall` (1 bit);
  - in READ, `i_stall` = 1 forces `o_rden` = 0 and holds k and L; the bubble propagates down the delay line;
  - `i_stall` is ignored in DRAIN, DONE and IDLE;
  - layer duration becomes N/2 + PIPE_LAT + (stalled READ cycles).
- Not defined: no `i_stall` port; READ never pauses.

## Structure
- Package `fft_pkg` holds:
  - the FSM state enum (IDLE, READ, DRAIN, DONE);
  - the helper functions for A/B/tw computation;
  - the width localparams derived from `FFT_SIZE`.
- Sub-module `fft_delay_line`:
  - parameters WIDTH and DEPTH;
  - synchronous active-low clear;
  - instantiated once with DEPTH = PIPE_LAT, WIDTH = 1+2·`ADDR_SIZE`.

## Test plan
- N=8, P=2, start pulse → layer 0 reads (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0; layer 1 (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2; layer 2 (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3; `o_done` at c+19.
- Write check, same run → every `o_wren`/`o_wraddr` equals `o_rden`/`o_rdaddr` from 2 cycles earlier. Exactly 12 write cycles. First read of each layer ≥1 cycle after the last write of the previous layer.
- `i_start` re-pulsed while busy, and again in the DONE cycle → no restart. A further pulse in IDLE → full second run, identical trace.
- `i_RST_N` = 0 during layer 1, k = 2 → next cycle all outputs at reset values, including `o_wren` = 0. No writes until a new start.
- N=16, P=3 → 4 layers of 11 cycles each. Layer 3 tw = 0..7, B = A+8. `o_done` at c+45.
- With `FFT_SEQ_STALL_EN`, `i_stall` high 3 cycles at layer 0, k = 1 → read address held, 3 write bubbles. `o_done` delayed by exactly 3 cycles.
